// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// MULT/MULTU run shift-add; DIV/DIVU run restoring division over 32 iterations plus a fix-up cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [DW-1:0]   a_raw_q, a_raw_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dbz_q, dbz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;

    logic            a_neg, b_neg, start_div, run_div, run_signed;
    logic [DW-1:0]   mag_a, mag_b;
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_diff;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quot_fix, rem_fix;

    // Operand conditioning at launch: magnitudes for signed ops, raw for unsigned.
    always_comb begin
        start_div = op[1];
        a_neg     = ~op[0] & operand_a[DW-1];
        b_neg     = ~op[0] & operand_b[DW-1];
        mag_a     = a_neg ? (~operand_a + DW'(1)) : operand_a;
        mag_b     = b_neg ? (~operand_b + DW'(1)) : operand_b;
    end

    // Per-iteration datapath and final sign correction.
    always_comb begin
        run_div    = op_q[1];
        run_signed = ~op_q[0];
        mul_sum    = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, mcand_q} : (DW+1)'(0));
        // Upper 33 bits of the left-shifted remainder minus the divisor; MSB set means negative.
        div_diff   = acc_q[2*DW-1:DW-1] - {1'b0, mcand_q};
        prod_fix   = (run_signed & neg_res_q) ? (~acc_q + (2*DW)'(1)) : acc_q;
        quot_fix   = (run_signed & neg_res_q) ? (~acc_q[DW-1:0] + DW'(1)) : acc_q[DW-1:0];
        rem_fix    = (run_signed & neg_rem_q) ? (~acc_q[2*DW-1:DW] + DW'(1)) : acc_q[2*DW-1:DW];
    end

    // Next-state and register update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    op_d      = op;
                    a_raw_d   = operand_a;
                    acc_d     = {{DW{1'b0}}, (start_div ? mag_a : mag_b)};
                    mcand_d   = start_div ? mag_b : mag_a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = start_div && (operand_b == '0);
                end else begin
                    if (hi_write) hi_d = write_data;
                    if (lo_write) lo_d = write_data;
                end
            end
            S_RUN: begin
                if (run_div) begin
                    if (div_diff[DW]) begin
                        acc_d = {acc_q[2*DW-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[DW-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(31)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!run_div) begin
                    hi_d = prod_fix[2*DW-1:DW];
                    lo_d = prod_fix[DW-1:0];
                end else if (dbz_q) begin
                    hi_d = a_raw_q;
                    lo_d = {DW{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            a_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            a_raw_q   <= a_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
